bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//   Multi-bit adder built on one instance of the 1-bit fulladder cell.
//   Operands are processed LSB first, one bit per clock; carry is held in a flop between bits.
//   Consumes the fulladder's sum/c_out every cycle and shifts the sum into a result register.
//   Sits upstream of datapath logic that needs area-cheap addition and tolerates WIDTH-cycle latency.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; sampled only in IDLE or DONE
//   a         in   WIDTH  operand A, captured on accepted start
//   b         in   WIDTH  operand B, captured on accepted start
//   c_in      in   1      carry-in, captured on accepted start
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle pulse; sum/c_out valid from this cycle
//   sum       out  WIDTH  result; holds until next accepted start
//   c_out     out  1      final carry; holds with sum
//   ovf       out  1      signed overflow (only with BIT_SERIAL_ADDER_OVF_EN)
// BEHAVIOUR
//   - One clock, asynchronous active-low reset, as decided above.
//   - Reset (async assert, sync release): state=IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0,
//     carry flop=0, bit counter=0, operand shift regs=0.
//   - FSM: IDLE -(start)-> RUN -(count==WIDTH-1)-> DONE -(start)-> RUN, -(!start)-> IDLE.
//   - Accept on edge with start=1 in IDLE/DONE: load a, b into shift regs, carry<=c_in, cnt<=0, clear sum reg.
//   - RUN, each edge: fulladder inputs a_sr[0], b_sr[0], carry;
//     sum reg <= {fa_sum, sum[WIDTH-1:1]}; carry <= fa_c_out; a_sr/b_sr shift right; cnt++.
//   - Latency: start accepted at edge k -> WIDTH bit edges k+1..k+WIDTH -> done=1 in the cycle after edge k+WIDTH.
//   - c_out <= fa_c_out on the last bit edge; sum/c_out stable from done until the next accept.
//   - done is high exactly one cycle (DONE state); busy=1 for exactly WIDTH cycles.
//   - start while busy: ignored, no effect on operands or count.
//   - start during done cycle: accepted; busy rises the next cycle; no IDLE gap.
//   - Operand inputs are don't-care except on the accept edge.
//   - rst_n low mid-RUN: immediate abort to reset values; no done pulse for the aborted add.
//   - Result is exact: {c_out,sum} == a + b + c_in (mod 2^(WIDTH+1)).
// CONFIGURATION
//   BIT_SERIAL_ADDER_OVF_EN defined: ovf port present; on the last bit edge
//     ovf <= carry_into_msb ^ fa_c_out (two's-complement overflow); held with sum; reset 0.
//   Not defined: ovf port and its logic absent; all other behaviour identical.
// TESTING (WIDTH=8)
//   1. a=0x00, b=0x00, c_in=0 -> done 8 cycles after accept; sum=0x00, c_out=0, ovf=0.
//   2. a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0; busy high exactly 8 cycles.
//   3. a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1 (OVF_EN build).
//   4. a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1; then start=1 in done cycle with 0x12+0x34 -> 0x46, no IDLE gap.
//   5. start pulsed at bit 3 of RUN with new operands -> ignored; original result returned.
//   6. rst_n low at bit 4 of 0xAA+0x55 -> all outputs 0 at once, no done; new add 0x0F+0x01 -> 0x10.

Source files
------------

// File: rtl/bit_serial_adder.sv
// bit_serial_adder -- area-cheap adder that pushes one bit per clock through a
// single 1-bit full-adder cell, LSB first, keeping the carry in a flop between
// bits. The result is ready WIDTH cycles after the operands are accepted.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; looked at only in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   c_in   in   carry-in, captured on an accepted start
//   busy   out  high while bits are being added (exactly WIDTH cycles)
//   done   out  one-cycle pulse; sum/c_out valid from this cycle on
//   sum    out  WIDTH-bit result, held until the next accepted start
//   c_out  out  final carry, held with sum
//   ovf    out  signed overflow, present only with BIT_SERIAL_ADDER_OVF_EN
//
// Build option: define BIT_SERIAL_ADDER_OVF_EN to add the ovf port and logic.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | adding one bit per clock
// S_DONE | result valid, done pulse; start here launches a new add at once

module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_c_out;

  fulladder u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          sum_d   = '0;
          c_out_d = 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // New bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_c_out;
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          c_out_d = fa_c_out;
`ifdef BIT_SERIAL_ADDER_OVF_EN
          // On the MSB bit, carry_q is the carry into the sign bit.
          ovf_d   = carry_q ^ fa_c_out;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: presents operands, lets the next rising edge
  // accept them, and returns at the following falling edge with garbage on
  // the operand inputs.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; c_in = cv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
  endtask

  // Starts at the first falling edge after the accept edge; returns at the
  // falling edge where done is seen (or when the budget runs out).
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: done never rose after %0d edges", edges);
    end
  endtask

  initial begin
    int edges, bc;
    bit saw_done;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h40, 8'h3F, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[7] = '{8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(c_out), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(edges, bc);
      check($sformatf("v%0d_latency", i), 32'(edges), 32'd8);
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd8);
      check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      check($sformatf("v%0d_cout", i), 32'(c_out), 32'(vecs[i].co));
`ifdef BIT_SERIAL_ADDER_OVF_EN
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
`endif
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_sum_hold", i), 32'(sum), 32'(vecs[i].s));
    end

    // Back-to-back: start during the done cycle, no idle gap.
    launch(8'hFF, 8'hFF, 1'b1);
    wait_done(edges, bc);
    check("b2b_first_sum", 32'(sum), 32'hFF);
    check("b2b_first_cout", 32'(c_out), 32'd1);
    launch(8'h12, 8'h34, 1'b0);
    check("b2b_busy_no_gap", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    wait_done(edges, bc);
    check("b2b_latency", 32'(edges), 32'd8);
    check("b2b_sum", 32'(sum), 32'h46);
    check("b2b_cout", 32'(c_out), 32'd0);
    @(negedge clk);

    // Start while busy is ignored.
    launch(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_still_busy", 32'(busy), 32'd1);
    wait_done(edges, bc);
    check("ign_latency", 32'(edges), 32'd4);
    check("ign_sum", 32'(sum), 32'h46);
    check("ign_cout", 32'(c_out), 32'd0);
    @(negedge clk);

    // Reset mid-run aborts immediately with no done pulse.
    launch(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(c_out), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    check("abort_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    launch(8'h0F, 8'h01, 1'b0);
    wait_done(edges, bc);
    check("post_abort_latency", 32'(edges), 32'd8);
    check("post_abort_sum", 32'(sum), 32'h10);
    check("post_abort_cout", 32'(c_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
